// File: rtl/uart_pkg.sv
// Shared UART types and helpers for the serial comm block set.
// Holds the receiver state encoding, parity mode codes and frame length helper.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_BREAK  = 3'd5
    } uart_rx_state_t;

    localparam int UART_PAR_NONE = 0;
    localparam int UART_PAR_ODD  = 1;
    localparam int UART_PAR_EVEN = 2;

    // Total bits on the line for one frame, start bit included.
    function automatic int uart_frame_bits(input int data_bits, input int parity, input int stop_bits);
        return 1 + data_bits + ((parity != UART_PAR_NONE) ? 1 : 0) + stop_bits;
    endfunction

endpackage

// File: rtl/uart_sync.sv
// N-flop synchroniser for asynchronous inputs; latency P_STAGES cycles.
// Reset value selectable so idle-high lines do not see a false edge out of reset.
module uart_sync #(
    parameter int P_STAGES  = 2,
    parameter bit P_RST_VAL = 1'b1
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic [P_STAGES-1:0] r_sync;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync <= {P_STAGES{P_RST_VAL}};
        end else begin
            r_sync <= {r_sync[P_STAGES-2:0], i_d};
        end
    end

    assign o_q = r_sync[P_STAGES-1];

endmodule

// File: rtl/uart_rx_os.sv
// Majority-voted UART receiver; parity hardware only when UART_RX_PARITY_EN is defined.
// o_valid rises t0+H+(N_BITS-1)*P_CLK_DIV+2; word held until i_ready, newer frames dropped with o_overrun.
module uart_rx_os
    import uart_pkg::*;
#(
    parameter int P_CLK_DIV     = 104,
    parameter int P_DATA_BITS   = 8,
    parameter int P_STOP_BITS   = 1,
    parameter int P_PARITY      = 2,
    parameter int P_SYNC_STAGES = 2
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_rx,
    output logic [P_DATA_BITS-1:0] o_data,
    output logic                   o_valid,
    input  logic                   i_ready,
    output logic                   o_parity_err,
    output logic                   o_frame_err,
    output logic                   o_overrun,
    output logic                   o_busy
);

`ifdef UART_RX_PARITY_EN
    localparam bit L_PAR_EN   = (P_PARITY != UART_PAR_NONE);
    localparam int L_PAR_MODE = P_PARITY;
`else
    localparam bit L_PAR_EN   = 1'b0;
    localparam int L_PAR_MODE = UART_PAR_NONE;
`endif

    localparam int L_CW     = $clog2(P_CLK_DIV);
    localparam int L_BW     = $clog2(P_DATA_BITS + 1);
    localparam int L_N_BITS = uart_frame_bits(P_DATA_BITS, L_PAR_MODE, P_STOP_BITS);

    localparam logic [L_CW-1:0] L_HALF      = L_CW'((P_CLK_DIV - 1) / 2);
    localparam logic [L_CW-1:0] L_LAST      = L_CW'(P_CLK_DIV - 1);
    localparam logic [L_CW-1:0] L_ONE       = L_CW'(1);
    localparam logic [L_BW-1:0] L_DATA_LAST = L_BW'(P_DATA_BITS - 1);
    localparam logic [L_BW-1:0] L_STOP_LAST = L_BW'(P_STOP_BITS - 1);

    generate
        if (P_CLK_DIV < 8 || P_CLK_DIV > 65535 || P_DATA_BITS < 5 || P_DATA_BITS > 9 ||
            P_STOP_BITS < 1 || P_STOP_BITS > 2 || P_PARITY < 0 || P_PARITY > 2 ||
            P_SYNC_STAGES < 2 || L_N_BITS > 13) begin : g_bad_param
            $error("uart_rx_os: parameter out of range");
        end
    endgenerate

    uart_rx_state_t r_state, w_state_nxt;

    logic                   w_rxs;
    logic [L_CW-1:0]        r_clk_cnt, w_clk_nxt, w_clk_inc;
    logic [L_BW-1:0]        r_bit_cnt, w_bit_nxt;
    logic                   r_armed, w_armed_nxt;
    logic [1:0]             r_hist;
    logic [P_DATA_BITS-1:0] r_shift;
    logic                   r_ferr, w_ferr_nxt;
    logic                   w_shift_en, w_par_ld, w_deliver;
    logic                   w_vote, w_resolve, w_accept, w_load;

    logic [P_DATA_BITS-1:0] r_data;
    logic                   r_valid, r_ferr_out, r_overrun;

    uart_sync #(
        .P_STAGES  (P_SYNC_STAGES),
        .P_RST_VAL (1'b1)
    ) u_sync (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_d   (i_rx),
        .o_q   (w_rxs)
    );

    // r_hist holds rxs at centre-1 and centre when a bit resolves at centre+1.
    assign w_vote    = (r_hist[1] & r_hist[0]) | (r_hist[1] & w_rxs) | (r_hist[0] & w_rxs);
    assign w_resolve = r_armed && (r_clk_cnt == L_ONE);
    assign w_clk_inc = (r_clk_cnt == L_LAST) ? '0 : r_clk_cnt + L_ONE;
    assign w_accept  = r_valid && i_ready;
    assign w_load    = w_deliver && (!r_valid || w_accept);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_clk_nxt   = w_clk_inc;
        w_bit_nxt   = r_bit_cnt;
        w_armed_nxt = r_armed;
        w_ferr_nxt  = r_ferr;
        w_shift_en  = 1'b0;
        w_par_ld    = 1'b0;
        w_deliver   = 1'b0;

        // clk_cnt is 0 at each bit centre; arm one cycle before so the start centre never resolves.
        if ((r_state == ST_DATA || r_state == ST_PARITY || r_state == ST_STOP) && r_clk_cnt == L_LAST) begin
            w_armed_nxt = 1'b1;
        end
        if (w_resolve) begin
            w_armed_nxt = 1'b0;
        end

        case (r_state)
            ST_IDLE: begin
                w_clk_nxt   = '0;
                w_bit_nxt   = '0;
                w_armed_nxt = 1'b0;
                w_ferr_nxt  = 1'b0;
                if (!w_rxs) begin
                    w_state_nxt = ST_START;
                    w_clk_nxt   = L_ONE;
                end
            end
            ST_START: begin
                if (r_clk_cnt == L_HALF) begin
                    if (w_rxs) begin
                        w_state_nxt = ST_IDLE;
                        w_clk_nxt   = '0;
                    end else begin
                        w_state_nxt = ST_DATA;
                        w_clk_nxt   = L_ONE;
                    end
                end
            end
            ST_DATA: begin
                if (w_resolve) begin
                    w_shift_en = 1'b1;
                    if (r_bit_cnt == L_DATA_LAST) begin
                        w_bit_nxt   = '0;
                        w_state_nxt = L_PAR_EN ? ST_PARITY : ST_STOP;
                    end else begin
                        w_bit_nxt = r_bit_cnt + L_BW'(1);
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (w_resolve) begin
                    w_par_ld    = 1'b1;
                    w_state_nxt = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (w_resolve) begin
                    if (!w_vote) begin
                        w_ferr_nxt = 1'b1;
                    end
                    if (r_bit_cnt == L_STOP_LAST) begin
                        w_deliver   = 1'b1;
                        w_clk_nxt   = '0;
                        w_bit_nxt   = '0;
                        w_state_nxt = (r_ferr || !w_vote) ? ST_BREAK : ST_IDLE;
                    end else begin
                        w_bit_nxt = r_bit_cnt + L_BW'(1);
                    end
                end
            end
            ST_BREAK: begin
                w_clk_nxt = '0;
                w_bit_nxt = '0;
                if (w_rxs) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_clk_nxt   = '0;
                w_bit_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_clk_cnt  <= '0;
            r_bit_cnt  <= '0;
            r_armed    <= 1'b0;
            r_hist     <= 2'b11;
            r_shift    <= '0;
            r_ferr     <= 1'b0;
            r_data     <= '0;
            r_valid    <= 1'b0;
            r_ferr_out <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            r_clk_cnt <= w_clk_nxt;
            r_bit_cnt <= w_bit_nxt;
            r_armed   <= w_armed_nxt;
            r_hist    <= {r_hist[0], w_rxs};
            r_ferr    <= w_ferr_nxt;
            if (w_shift_en) begin
                r_shift <= {w_vote, r_shift[P_DATA_BITS-1:1]};
            end
            r_overrun <= w_deliver && r_valid && !w_accept;
            // An accept in the delivery cycle frees the slot, so the new word loads without overrun.
            if (w_load) begin
                r_data     <= r_shift;
                r_valid    <= 1'b1;
                r_ferr_out <= w_ferr_nxt;
            end else if (w_accept) begin
                r_valid    <= 1'b0;
                r_ferr_out <= 1'b0;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    logic r_perr, r_perr_out;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_perr     <= 1'b0;
            r_perr_out <= 1'b0;
        end else begin
            if (r_state == ST_IDLE) begin
                r_perr <= 1'b0;
            end else if (w_par_ld) begin
                r_perr <= (^r_shift) ^ w_vote ^ (L_PAR_MODE == UART_PAR_ODD);
            end
            if (w_load) begin
                r_perr_out <= r_perr;
            end else if (w_accept) begin
                r_perr_out <= 1'b0;
            end
        end
    end

    assign o_parity_err = r_perr_out;
`else
    assign o_parity_err = 1'b0;
`endif

    assign o_data      = r_data;
    assign o_valid     = r_valid;
    assign o_frame_err = r_ferr_out;
    assign o_overrun   = r_overrun;
    assign o_busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_os.sv
// Scoreboard bench for uart_rx_os at 16 clocks per bit, 8 data bits, 1 stop bit.
// Stimulus pushes expected words; the monitor pops and compares on every accepted word.
module tb_uart_rx_os;

    localparam int CLK_DIV = 16;
`ifdef UART_RX_PARITY_EN
    localparam bit TB_PAR = 1'b1;
`else
    localparam bit TB_PAR = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       i_rst, i_rx, i_ready;
    logic [7:0] o_data;
    logic       o_valid, o_parity_err, o_frame_err, o_overrun, o_busy;

    typedef struct packed {
        logic [7:0] d;
        logic       perr;
        logic       ferr;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   n_valid_cyc = 0;
    int   n_ovr = 0;

    always #5 clk = ~clk;

    uart_rx_os #(
        .P_CLK_DIV     (CLK_DIV),
        .P_DATA_BITS   (8),
        .P_STOP_BITS   (1),
        .P_PARITY      (2),
        .P_SYNC_STAGES (2)
    ) dut (
        .i_clk        (clk),
        .i_rst        (i_rst),
        .i_rx         (i_rx),
        .o_data       (o_data),
        .o_valid      (o_valid),
        .i_ready      (i_ready),
        .o_parity_err (o_parity_err),
        .o_frame_err  (o_frame_err),
        .o_overrun    (o_overrun),
        .o_busy       (o_busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic exp_push(input logic [7:0] d, input logic perr, input logic ferr);
        exp_t e;
        e.d    = d;
        e.perr = perr;
        e.ferr = ferr;
        sb_q.push_back(e);
    endtask

    task automatic send_bit(input logic b, input bit glitch);
        for (int c = 0; c < CLK_DIV; c++) begin
            i_rx = (glitch && c == 7) ? ~b : b;
            @(negedge clk);
        end
    endtask

    // Even parity bit when the parity build is active; par_bad inverts it.
    task automatic send_frame(input logic [7:0] d, input bit par_bad, input logic stop_val, input bit glitch);
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            send_bit(d[i], glitch);
        end
        if (TB_PAR) begin
            send_bit((^d) ^ par_bad, 1'b0);
        end
        send_bit(stop_val, 1'b0);
    endtask

    task automatic wait_drain(input string name, input int budget);
        int k;
        k = 0;
        while (sb_q.size() != 0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk(name, sb_q.size(), 0);
    endtask

    task automatic set_ready(input logic v);
        @(posedge clk);
        #1 i_ready = v;
        @(negedge clk);
    endtask

    // Monitor: compare every word the consumer takes against the scoreboard head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!i_rst) begin
                if (o_valid) n_valid_cyc++;
                if (o_overrun) n_ovr++;
                if (o_valid && i_ready) begin
                    n_checks++;
                    if (sb_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL unexpected_word: got data=0x%0h perr=%0b ferr=%0b, none expected",
                                 o_data, o_parity_err, o_frame_err);
                    end else begin
                        e = sb_q.pop_front();
                        if ({o_data, o_parity_err, o_frame_err} !== e) begin
                            n_fail++;
                            $display("FAIL word: got data=0x%0h perr=%0b ferr=%0b expected data=0x%0h perr=%0b ferr=%0b",
                                     o_data, o_parity_err, o_frame_err, e.d, e.perr, e.ferr);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail + 1);
        $fatal(1);
    end

    initial begin
        int  v0, o0;
        bit  saw_busy;
        i_rst   = 1'b1;
        i_rx    = 1'b1;
        i_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_data", o_data, 0);
        chk("rst_valid", o_valid, 0);
        chk("rst_perr", o_parity_err, 0);
        chk("rst_ferr", o_frame_err, 0);
        chk("rst_overrun", o_overrun, 0);
        chk("rst_busy", o_busy, 0);
        i_rst = 1'b0;
        repeat (5) @(negedge clk);

        // 8N1 0xA5: single-cycle valid, no errors, no overrun
        v0 = n_valid_cyc;
        o0 = n_ovr;
        exp_push(8'hA5, 1'b0, 1'b0);
        send_frame(8'hA5, 1'b0, 1'b1, 1'b0);
        i_rx = 1'b1;
        wait_drain("a5_drain", 200);
        repeat (4) @(negedge clk);
        chk("a5_valid_cycles", n_valid_cyc - v0, 1);
        chk("a5_overrun", n_ovr - o0, 0);

        // back-to-back frames, start bit directly after stop bit
        exp_push(8'hC3, 1'b0, 1'b0);
        exp_push(8'h3C, 1'b0, 1'b0);
        send_frame(8'hC3, 1'b0, 1'b1, 1'b0);
        send_frame(8'h3C, 1'b0, 1'b1, 1'b0);
        i_rx = 1'b1;
        wait_drain("b2b_drain", 200);

        // wrong parity bit on 0x03 (parity error only in the parity build)
        exp_push(8'h03, TB_PAR, 1'b0);
        send_frame(8'h03, 1'b1, 1'b1, 1'b0);
        i_rx = 1'b1;
        wait_drain("par_drain", 200);
        repeat (8) @(negedge clk);

        // stop bit low, line held low 3 bit times, then a clean 0x12
        exp_push(8'h55, 1'b0, 1'b1);
        exp_push(8'h12, 1'b0, 1'b0);
        send_frame(8'h55, 1'b0, 1'b0, 1'b0);
        repeat (24) @(negedge clk);
        chk("break_busy", o_busy, 1);
        repeat (24) @(negedge clk);
        i_rx = 1'b1;
        repeat (32) @(negedge clk);
        chk("break_exit_busy", o_busy, 0);
        chk("break_one_word", sb_q.size(), 1);
        send_frame(8'h12, 1'b0, 1'b1, 1'b0);
        i_rx = 1'b1;
        wait_drain("ferr_drain", 200);
        repeat (8) @(negedge clk);

        // 4-cycle low glitch on idle line
        v0 = n_valid_cyc;
        saw_busy = 1'b0;
        i_rx = 1'b0;
        for (int c = 0; c < 12; c++) begin
            if (c == 4) i_rx = 1'b1;
            @(negedge clk);
            if (o_busy) saw_busy = 1'b1;
        end
        chk("glitch_busy_seen", saw_busy, 1);
        chk("glitch_busy_clear", o_busy, 0);
        repeat (200) @(negedge clk);
        chk("glitch_no_valid", n_valid_cyc - v0, 0);

        // i_ready low: 0x11 held, 0x22 dropped with one overrun pulse
        set_ready(1'b0);
        o0 = n_ovr;
        exp_push(8'h11, 1'b0, 1'b0);
        send_frame(8'h11, 1'b0, 1'b1, 1'b0);
        send_frame(8'h22, 1'b0, 1'b1, 1'b0);
        i_rx = 1'b1;
        repeat (10) @(negedge clk);
        chk("ovr_valid_held", o_valid, 1);
        chk("ovr_data_held", o_data, 8'h11);
        chk("ovr_pulses", n_ovr - o0, 1);
        set_ready(1'b1);
        wait_drain("ovr_drain", 10);
        repeat (3) @(negedge clk);
        chk("ovr_valid_drop", o_valid, 0);
        chk("ovr_data_keep", o_data, 8'h11);

        // single-cycle inverted glitch at each data-bit centre of 0x0F
        exp_push(8'h0F, 1'b0, 1'b0);
        send_frame(8'h0F, 1'b0, 1'b1, 1'b1);
        i_rx = 1'b1;
        wait_drain("vote_drain", 200);

        // reset mid-frame while a word is held
        set_ready(1'b0);
        send_frame(8'h3C, 1'b0, 1'b1, 1'b0);
        i_rx = 1'b1;
        repeat (10) @(negedge clk);
        chk("pre_rst_valid", o_valid, 1);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        chk("pre_rst_busy", o_busy, 1);
        #2 i_rst = 1'b1;
        #1;
        chk("mid_rst_data", o_data, 0);
        chk("mid_rst_valid", o_valid, 0);
        chk("mid_rst_flags", {o_parity_err, o_frame_err, o_overrun}, 0);
        chk("mid_rst_busy", o_busy, 0);
        i_rx = 1'b1;
        repeat (4) @(negedge clk);
        i_rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("post_rst_idle", o_busy, 0);
        set_ready(1'b1);
        exp_push(8'h5A, 1'b0, 1'b0);
        send_frame(8'h5A, 1'b0, 1'b1, 1'b0);
        i_rx = 1'b1;
        wait_drain("post_rst_drain", 200);
        repeat (10) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
